// File: rtl/io_mailbox_pkg.sv
// Shared constants for the io_mailbox IO responder: register offsets,
// STATUS bit positions, default window base and the write-lane selector.
package io_mailbox_pkg;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFF00;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RXCNT  = 2'd2;
    localparam logic [1:0] REG_TXCNT  = 2'd3;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_OVF      = 3;
    localparam int OVF_CLR_BIT = 3;

    // The core presents the written byte on the upper lane unless n_lb is high.
    function automatic logic [7:0] lane_select(input logic [15:0] d, input logic n_lb);
        return n_lb ? d[7:0] : d[15:8];
    endfunction

endpackage

// File: rtl/io_mailbox_byte_fifo.sv
// byte_fifo: circular byte FIFO with occupancy count. Full/empty are judged on
// the registered count, so a push into a full FIFO is refused even if it pops.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign count_d   = count_q + (AW + 1)'(push_ok_s) - (AW + 1)'(pop_ok_s);

    // Storage, pointers and count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/io_mailbox.sv
// io_mailbox: CPU IO-strobe responder bridging byte writes/reads to TX/RX FIFOs.
// Build option IO_MAILBOX_STALL_EN: stall the core on a write to a full TX FIFO
// instead of dropping the byte and raising the sticky overflow flag.
module io_mailbox
    import io_mailbox_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 8,
    parameter int          AW        = 3
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] address,
    input  logic [15:0] data_out,
    input  logic        io_wc,
    input  logic        io_rc,
    input  logic        io_n_lb_w,
    input  logic        io_n_lb_r,
    output logic [15:0] data_in,
    output logic        io_stall,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    logic          hit_s;
    logic          wr_cyc_s;
    logic          rd_cyc_s;
    logic [1:0]    reg_s;
    logic [7:0]    wb_s;
    logic          io_stall_s;
    logic          ovf_set_s;
    logic          ovf_q;
    logic          ovf_d;
    logic          tx_push_s;
    logic          tx_pop_s;
    logic          tx_full_s;
    logic          tx_empty_s;
    logic [AW:0]   tx_count_s;
    logic          rx_push_s;
    logic          rx_pop_s;
    logic          rx_full_s;
    logic          rx_empty_s;
    logic [AW:0]   rx_count_s;
    logic [7:0]    rx_head_s;
    logic [7:0]    rd_byte_s;
    logic          unused_s;

    assign hit_s    = (address[15:2] == BASE_ADDR[15:2]);
    assign reg_s    = address[1:0];
    // A simultaneous write and read is treated as the write alone.
    assign wr_cyc_s = io_wc & hit_s;
    assign rd_cyc_s = io_rc & hit_s & ~io_wc;
    assign wb_s     = lane_select(data_out, io_n_lb_w);
    assign unused_s = io_n_lb_r;

`ifdef IO_MAILBOX_STALL_EN
    assign io_stall_s = wr_cyc_s & (reg_s == REG_DATA) & tx_full_s;
    assign ovf_set_s  = 1'b0;
`else
    assign io_stall_s = 1'b0;
    assign ovf_set_s  = wr_cyc_s & (reg_s == REG_DATA) & tx_full_s;
`endif

    assign tx_push_s = wr_cyc_s & (reg_s == REG_DATA) & ~io_stall_s & ~tx_full_s;
    assign tx_pop_s  = ~tx_empty_s & tx_ready;
    assign rx_push_s = rx_valid & ~rx_full_s;
    assign rx_pop_s  = rd_cyc_s & (reg_s == REG_DATA) & ~rx_empty_s;

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) tx_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (tx_push_s),
        .din     (wb_s),
        .pop     (tx_pop_s),
        .head    (tx_data),
        .full    (tx_full_s),
        .empty   (tx_empty_s),
        .count   (tx_count_s)
    );

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) rx_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (rx_push_s),
        .din     (rx_data),
        .pop     (rx_pop_s),
        .head    (rx_head_s),
        .full    (rx_full_s),
        .empty   (rx_empty_s),
        .count   (rx_count_s)
    );

    // Sticky overflow flag: a STATUS clear takes priority over a new drop.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_cyc_s && (reg_s == REG_STATUS) && wb_s[OVF_CLR_BIT]) begin
            ovf_d = 1'b0;
        end else if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Read-data mux; both lanes carry the same byte.
    always_comb begin
        rd_byte_s = 8'h00;
        if (io_rc && hit_s) begin
            case (reg_s)
                REG_DATA:   rd_byte_s = rx_empty_s ? 8'h00 : rx_head_s;
                REG_STATUS: begin
                    rd_byte_s              = 8'h00;
                    rd_byte_s[ST_OVF]      = ovf_q;
                    rd_byte_s[ST_TX_FULL]  = tx_full_s;
                    rd_byte_s[ST_TX_EMPTY] = tx_empty_s;
                    rd_byte_s[ST_RX_EMPTY] = rx_empty_s;
                end
                REG_RXCNT:  rd_byte_s = 8'(rx_count_s);
                REG_TXCNT:  rd_byte_s = 8'(tx_count_s);
                default:    rd_byte_s = 8'h00;
            endcase
        end else begin
            rd_byte_s = 8'h00;
        end
    end

    assign data_in  = {rd_byte_s, rd_byte_s};
    assign io_stall = io_stall_s;
    assign tx_valid = ~tx_empty_s;
    assign rx_ready = ~rx_full_s;

endmodule
